// File: rtl/ddrphy_lane_delay_trainer_if.sv
// IOD delay-line and eye-monitor bundle between the lane trainer
// (master) and the per-lane IOD delay/eye-monitor ports (slave).
interface ddrphy_lane_delay_trainer_if #(
   parameter int NUM_LANES = 4
);
   logic [NUM_LANES-1:0] DELAY_LINE_LOAD;
   logic [NUM_LANES-1:0] DELAY_LINE_MOVE;
   logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION;
   logic [NUM_LANES-1:0] EYE_MONITOR_CLEAR_FLAGS;
   logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE;
   logic [NUM_LANES-1:0] EYE_MONITOR_EARLY;
   logic [NUM_LANES-1:0] EYE_MONITOR_LATE;

   modport master (
      output DELAY_LINE_LOAD,
      output DELAY_LINE_MOVE,
      output DELAY_LINE_DIRECTION,
      output EYE_MONITOR_CLEAR_FLAGS,
      input  DELAY_LINE_OUT_OF_RANGE,
      input  EYE_MONITOR_EARLY,
      input  EYE_MONITOR_LATE
   );

   modport slave (
      input  DELAY_LINE_LOAD,
      input  DELAY_LINE_MOVE,
      input  DELAY_LINE_DIRECTION,
      input  EYE_MONITOR_CLEAR_FLAGS,
      output DELAY_LINE_OUT_OF_RANGE,
      output EYE_MONITOR_EARLY,
      output EYE_MONITOR_LATE
   );
endinterface

// File: rtl/ddrphy_lane_delay_trainer.sv
// Sequential per-lane read-delay sweep and window centring.
// Optional WINDOW_WIDTH report: define LANE_TRAINER_WINDOW_REPORT_EN.
module ddrphy_lane_delay_trainer #(
   parameter int NUM_LANES     = 4,
   parameter int TAP_BITS      = 7,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16
) (
   input  logic                          FAB_CLK,
   input  logic                          SYNC_RST,
   input  logic                          START,
   output logic                          BUSY,
   output logic                          DONE,
   output logic [NUM_LANES-1:0]          LANE_FAIL,
   output logic [NUM_LANES*TAP_BITS-1:0] CENTER_TAP,
   ddrphy_lane_delay_trainer_if.master   iod
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
   ,
   output logic [NUM_LANES*(TAP_BITS+1)-1:0] WINDOW_WIDTH
`endif
);

   localparam int CMAX =
      (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [LW-1:0] LAST_LANE   = LW'(NUM_LANES - 1);
   localparam logic [NUM_LANES-1:0] ONE  = NUM_LANES'(1);
   localparam logic [TAP_BITS-1:0] TAP_MAX = {TAP_BITS{1'b1}};

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_SETTLE,
      S_SAMPLE,
      S_EVAL,
      S_STEP,
      S_CLOAD,
      S_CSTEP,
      S_NEXT,
      S_FINISH
   } state_t;

   state_t              state;
   logic [LW-1:0]       lane;
   logic [TAP_BITS-1:0] tap;
   logic [TAP_BITS-1:0] first;
   logic [TAP_BITS-1:0] last;
   logic                seen_pass;
   logic                fail_bit;
   logic [CW-1:0]       cnt;
   logic [TAP_BITS:0]   target;
   logic [TAP_BITS:0]   step_cnt;
   logic [NUM_LANES-1:0] load_q;
   logic [NUM_LANES-1:0] move_q;
   logic [NUM_LANES-1:0] clr_q;

   logic [NUM_LANES-1:0] lane_oh;
   logic [NUM_LANES-1:0] next_oh;
   logic [LW-1:0]        lane_nxt;
   logic [TAP_BITS:0]    mid;
   logic [TAP_BITS:0]    win;
   logic                 end_sweep;
   logic                 flag_now;

   assign lane_nxt  = lane + LW'(1);
   assign lane_oh   = ONE << lane;
   assign next_oh   = ONE << lane_nxt;
   // Sum is one bit wider than a tap so 2**TAP_BITS-1 twice cannot wrap.
   assign mid       = ({1'b0, first} + {1'b0, last}) >> 1;
   assign win       = {1'b0, last} - {1'b0, first} + (TAP_BITS + 1)'(1);
   assign end_sweep = (tap == TAP_MAX) ||
                      iod.DELAY_LINE_OUT_OF_RANGE[lane];
   assign flag_now  = iod.EYE_MONITOR_EARLY[lane] |
                      iod.EYE_MONITOR_LATE[lane];

   assign iod.DELAY_LINE_LOAD         = load_q;
   assign iod.DELAY_LINE_MOVE         = move_q;
   assign iod.EYE_MONITOR_CLEAR_FLAGS = clr_q;
   assign iod.DELAY_LINE_DIRECTION    = '1;

   // Pulses are set on the transition into the state that owns them,
   // so each one is a registered single-cycle strobe.
   always_ff @(posedge FAB_CLK) begin
      load_q <= '0;
      move_q <= '0;
      clr_q  <= '0;
      DONE   <= 1'b0;
      if (SYNC_RST) begin
         state      <= S_IDLE;
         BUSY       <= 1'b0;
         LANE_FAIL  <= '0;
         CENTER_TAP <= '0;
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
         WINDOW_WIDTH <= '0;
`endif
         lane       <= '0;
         tap        <= '0;
         first      <= '0;
         last       <= '0;
         seen_pass  <= 1'b0;
         fail_bit   <= 1'b0;
         cnt        <= '0;
         target     <= '0;
         step_cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (START) begin
                  BUSY      <= 1'b1;
                  lane      <= '0;
                  LANE_FAIL <= '0;
                  load_q    <= ONE;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               tap       <= '0;
               seen_pass <= 1'b0;
               first     <= '0;
               last      <= '0;
               clr_q     <= lane_oh;
               state     <= S_CLEAR;
            end
            S_CLEAR: begin
               cnt   <= '0;
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt      <= '0;
                  fail_bit <= 1'b0;
                  state    <= S_SAMPLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_SAMPLE: begin
               fail_bit <= fail_bit | flag_now;
               if (cnt == SAMPLE_LAST) begin
                  state <= S_EVAL;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_EVAL: begin
               if (!fail_bit) begin
                  if (!seen_pass) first <= tap;
                  last      <= tap;
                  seen_pass <= 1'b1;
               end
               if ((fail_bit && seen_pass) || end_sweep) begin
                  load_q <= lane_oh;
                  state  <= S_CLOAD;
               end else begin
                  move_q <= lane_oh;
                  state  <= S_STEP;
               end
            end
            S_STEP: begin
               tap   <= tap + TAP_BITS'(1);
               clr_q <= lane_oh;
               state <= S_CLEAR;
            end
            S_CLOAD: begin
               step_cnt <= '0;
               if (!seen_pass) begin
                  LANE_FAIL[lane] <= 1'b1;
                  target          <= '0;
               end else begin
                  target <= mid;
               end
               state <= S_CSTEP;
            end
            S_CSTEP: begin
               if (step_cnt == target) begin
                  CENTER_TAP[32'(lane)*TAP_BITS +: TAP_BITS] <=
                     target[TAP_BITS-1:0];
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
                  WINDOW_WIDTH[32'(lane)*(TAP_BITS+1) +: TAP_BITS+1] <=
                     seen_pass ? win : '0;
`endif
                  state <= S_NEXT;
               end else begin
                  move_q   <= lane_oh;
                  step_cnt <= step_cnt + (TAP_BITS + 1)'(1);
               end
            end
            S_NEXT: begin
               if (lane == LAST_LANE) begin
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= S_FINISH;
               end else begin
                  lane   <= lane_nxt;
                  load_q <= next_oh;
                  state  <= S_LOAD;
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifndef LANE_TRAINER_WINDOW_REPORT_EN
   logic unused_win;
   assign unused_win = ^win;
`endif

endmodule

// File: tb/tb_ddrphy_lane_delay_trainer.sv
// Randomised scoreboard bench for ddrphy_lane_delay_trainer with a
// tap-tracking delay-line / eye-monitor model.
module tb_ddrphy_lane_delay_trainer;

   localparam int NL = 2;
   localparam int TB = 5;
   localparam int SC = 2;
   localparam int SA = 4;
   localparam int TMAX = (1 << TB) - 1;
   localparam int TAP_COST = 1 + SC + SA + 1 + 1;
   localparam int NO_OOR = 1000;

   typedef struct packed {
      logic [NL*TB-1:0]     center;
      logic [NL-1:0]        fail;
      logic [NL*(TB+1)-1:0] width;
      logic [NL*TB-1:0]     final_tap;
   } exp_t;

   logic FAB_CLK = 1'b0;
   logic SYNC_RST = 1'b1;
   logic START = 1'b0;
   logic BUSY;
   logic DONE;
   logic [NL-1:0] LANE_FAIL;
   logic [NL*TB-1:0] CENTER_TAP;
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
   logic [NL*(TB+1)-1:0] WINDOW_WIDTH;
`endif

   ddrphy_lane_delay_trainer_if #(.NUM_LANES(NL)) iod ();

   ddrphy_lane_delay_trainer #(
      .NUM_LANES    (NL),
      .TAP_BITS     (TB),
      .SETTLE_CYCLES(SC),
      .SAMPLE_CYCLES(SA)
   ) dut (
      .FAB_CLK   (FAB_CLK),
      .SYNC_RST  (SYNC_RST),
      .START     (START),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .LANE_FAIL (LANE_FAIL),
      .CENTER_TAP(CENTER_TAP),
      .iod       (iod)
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
      ,
      .WINDOW_WIDTH(WINDOW_WIDTH)
`endif
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int n_checks = 0;
   int n_fail = 0;

   int lo [NL];
   int hi [NL];
   int oor_at [NL];
   bit gl_en;
   int gl_lane;
   int gl_tap;
   int tap_m [NL];
   int since_clr [NL];
   exp_t sb_q [$];

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   function automatic bit in_window(int l, int t);
      return (t >= lo[l]) && (t <= hi[l]);
   endfunction

   // Reference: walk taps upward, take the first contiguous passing run.
   function automatic exp_t model();
      exp_t e;
      e = '0;
      for (int l = 0; l < NL; l++) begin
         int first = -1;
         int last = -1;
         int c = 0;
         int w = 0;
         for (int t = 0; t <= TMAX; t++) begin
            bit p;
            p = in_window(l, t) && !(gl_en && gl_lane == l && gl_tap == t);
            if (p) begin
               if (first < 0) first = t;
               last = t;
            end else if (first >= 0) begin
               break;
            end
            if (t == TMAX || t >= oor_at[l]) break;
         end
         if (first < 0) begin
            e.fail[l] = 1'b1;
         end else begin
            c = (first + last) / 2;
            w = last - first + 1;
         end
         e.center[l*TB +: TB] = TB'(c);
         e.final_tap[l*TB +: TB] = TB'(c);
         e.width[l*(TB+1) +: TB+1] = (TB + 1)'(w);
      end
      return e;
   endfunction

   // Delay-line and eye-monitor model.
   initial begin
      int r;
      bit bad;
      iod.DELAY_LINE_OUT_OF_RANGE = '0;
      iod.EYE_MONITOR_EARLY = '0;
      iod.EYE_MONITOR_LATE = '0;
      for (int l = 0; l < NL; l++) begin
         tap_m[l] = 0;
         since_clr[l] = 100;
      end
      forever begin
         @(negedge FAB_CLK);
         for (int l = 0; l < NL; l++) begin
            if (iod.DELAY_LINE_LOAD[l]) tap_m[l] = 0;
            else if (iod.DELAY_LINE_MOVE[l])
               tap_m[l] += iod.DELAY_LINE_DIRECTION[l] ? 1 : -1;
            if (iod.EYE_MONITOR_CLEAR_FLAGS[l]) since_clr[l] = 0;
            else if (since_clr[l] < 100) since_clr[l]++;
            bad = !in_window(l, tap_m[l]) ||
                  (gl_en && gl_lane == l && gl_tap == tap_m[l] &&
                   since_clr[l] == SC + 3);
            r = bad ? $urandom_range(1, 3) : 0;
            iod.EYE_MONITOR_EARLY[l] = r[0];
            iod.EYE_MONITOR_LATE[l] = r[1];
            iod.DELAY_LINE_OUT_OF_RANGE[l] = (tap_m[l] >= oor_at[l]);
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      int cyc = 0;
      int loads [NL];
      int last_clr [NL];
      int excl = 0;
      int np;
      exp_t e;
      for (int l = 0; l < NL; l++) begin
         loads[l] = 0;
         last_clr[l] = -1;
      end
      forever begin
         @(negedge FAB_CLK);
         cyc++;
         if (SYNC_RST) begin
            excl = 0;
            for (int l = 0; l < NL; l++) begin
               loads[l] = 0;
               last_clr[l] = -1;
            end
         end else begin
            np = $countones(iod.DELAY_LINE_LOAD) +
                 $countones(iod.DELAY_LINE_MOVE) +
                 $countones(iod.EYE_MONITOR_CLEAR_FLAGS);
            if (np > 1) excl++;
            for (int l = 0; l < NL; l++) begin
               if (iod.DELAY_LINE_LOAD[l]) begin
                  loads[l]++;
                  last_clr[l] = -1;
               end
               if (iod.EYE_MONITOR_CLEAR_FLAGS[l]) begin
                  if (last_clr[l] >= 0)
                     check("tap_cost", 64'(cyc - last_clr[l]), TAP_COST);
                  last_clr[l] = cyc;
               end
            end
            if (DONE) begin
               check("done_expected", 64'(sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check("center_tap", 64'(CENTER_TAP), 64'(e.center));
                  check("lane_fail", 64'(LANE_FAIL), 64'(e.fail));
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
                  check("window_width", 64'(WINDOW_WIDTH), 64'(e.width));
`endif
                  for (int l = 0; l < NL; l++) begin
                     check("final_tap", 64'(tap_m[l]),
                           64'(e.final_tap[l*TB +: TB]));
                     check("load_pulses", 64'(loads[l]), 2);
                     loads[l] = 0;
                  end
               end
               check("busy_at_done", 64'(BUSY), 0);
               check("pulse_exclusive", 64'(excl), 0);
               excl = 0;
            end
         end
      end
   end

   task automatic set_cfg(input int lo0, input int hi0, input int lo1,
                          input int hi1, input int oor0, input int oor1);
      lo[0] = lo0;
      hi[0] = hi0;
      lo[1] = lo1;
      hi[1] = hi1;
      oor_at[0] = oor0;
      oor_at[1] = oor1;
      gl_en = 1'b0;
      gl_lane = 0;
      gl_tap = 0;
   endtask

   task automatic do_reset();
      SYNC_RST = 1'b1;
      repeat (2) @(negedge FAB_CLK);
      SYNC_RST = 1'b0;
   endtask

   task automatic run(input string nm, input int spur);
      bit got;
      sb_q.push_back(model());
      @(negedge FAB_CLK);
      START = 1'b1;
      @(negedge FAB_CLK);
      START = 1'b0;
      if (spur > 0) begin
         repeat (spur) @(negedge FAB_CLK);
         check("busy_mid_sweep", 64'(BUSY), 1);
         START = 1'b1;
         @(negedge FAB_CLK);
         START = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         @(negedge FAB_CLK);
         if (DONE) got = 1'b1;
      end
      check({"done_", nm}, 64'(got), 1);
      if (!got) begin
         sb_q.delete();
         do_reset();
      end
   endtask

   task automatic check_reset_values(input string nm);
      check({nm, "_busy"}, 64'(BUSY), 0);
      check({nm, "_done"}, 64'(DONE), 0);
      check({nm, "_lane_fail"}, 64'(LANE_FAIL), 0);
      check({nm, "_center"}, 64'(CENTER_TAP), 0);
      check({nm, "_pulses"}, 64'({iod.DELAY_LINE_LOAD, iod.DELAY_LINE_MOVE,
                                  iod.EYE_MONITOR_CLEAR_FLAGS}), 0);
      check({nm, "_direction"}, 64'(iod.DELAY_LINE_DIRECTION), 64'(2'b11));
`ifdef LANE_TRAINER_WINDOW_REPORT_EN
      check({nm, "_window"}, 64'(WINDOW_WIDTH), 0);
`endif
   endtask

   task automatic reset_mid_lane1();
      bit got;
      int noisy;
      set_cfg(6, 14, 3, 4, NO_OOR, NO_OOR);
      sb_q.push_back(model());
      @(negedge FAB_CLK);
      START = 1'b1;
      @(negedge FAB_CLK);
      START = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 2000 && !got; k++) begin
         @(negedge FAB_CLK);
         if (iod.DELAY_LINE_LOAD[1]) got = 1'b1;
      end
      check("lane1_reached", 64'(got), 1);
      repeat (20) @(negedge FAB_CLK);
      SYNC_RST = 1'b1;
      @(negedge FAB_CLK);
      check_reset_values("mid_reset");
      @(negedge FAB_CLK);
      SYNC_RST = 1'b0;
      void'(sb_q.pop_back());
      noisy = 0;
      repeat (40) begin
         @(negedge FAB_CLK);
         if (|{iod.DELAY_LINE_LOAD, iod.DELAY_LINE_MOVE,
               iod.EYE_MONITOR_CLEAR_FLAGS, DONE, BUSY}) noisy++;
      end
      check("quiet_after_reset", 64'(noisy), 0);
   endtask

   initial begin
      int a;
      int b;
      set_cfg(1, 0, 1, 0, NO_OOR, NO_OOR);
      SYNC_RST = 1'b1;
      repeat (3) @(negedge FAB_CLK);
      check_reset_values("reset");
      SYNC_RST = 1'b0;

      set_cfg(6, 14, 3, 4, NO_OOR, NO_OOR);
      run("basic", 0);
      set_cfg(9, 20, 1, 0, NO_OOR, NO_OOR);
      run("lane1_no_pass", 0);
      set_cfg(28, 31, 0, 0, NO_OOR, NO_OOR);
      run("sweep_limit", 0);
      set_cfg(18, 25, 2, 7, 20, NO_OOR);
      run("out_of_range", 0);
      set_cfg(5, 12, 10, 11, NO_OOR, NO_OOR);
      gl_en = 1'b1;
      gl_lane = 0;
      gl_tap = 8;
      run("early_glitch", 0);
      set_cfg(6, 14, 3, 4, NO_OOR, NO_OOR);
      run("start_while_busy", 60);

      for (int i = 0; i < 6; i++) begin
         for (int l = 0; l < NL; l++) begin
            a = $urandom_range(0, TMAX);
            b = $urandom_range(0, 12);
            lo[l] = a;
            hi[l] = (a + b - 1 > TMAX) ? TMAX : a + b - 1;
            oor_at[l] = ($urandom_range(0, 1) == 1) ?
                        $urandom_range(0, TMAX) : NO_OOR;
         end
         gl_en = ($urandom_range(0, 3) == 0);
         gl_lane = $urandom_range(0, NL - 1);
         gl_tap = lo[gl_lane] + 1;
         run("random", 0);
      end

      reset_mid_lane1();
      set_cfg(0, 31, 30, 31, NO_OOR, NO_OOR);
      run("after_reset", 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ddrphy_lane_delay_trainer.md
# ddrphy_lane_delay_trainer

Parametrised, multi-lane read-delay training engine for the DDR4 PHY lane IODs. For each of `NUM_LANES` lanes in turn, it sweeps the IOD dynamic delay line one tap at a time and uses the lane eye-monitor EARLY/LATE flags to find the first contiguous passing window. It then reloads the delay line and steps it to the window centre. It sits in the fabric `FAB_CLK` domain, between the PHY training sequencer and the per-lane IOD delay/eye-monitor ports.

## Interface
Parameters:
- `NUM_LANES`, 4 — lanes trained, processed sequentially from lane 0 upward.
- `TAP_BITS`, 7 — tap counter width; the sweep limit is `2**TAP_BITS-1`.
- `SETTLE_CYCLES`, 8 — wait after flag clear before sampling, ≥1.
- `SAMPLE_CYCLES`, 16 — eye-monitor observation window per tap, ≥1.

Ports:
- `FAB_CLK` in 1 — the only clock; all logic is rising-edge.
- `SYNC_RST` in 1 — synchronous, active-high reset.
- `START` in 1 — single-cycle request; ignored while `BUSY`.
- `BUSY` out 1 — training in progress.
- `DONE` out 1 — one-cycle pulse when all lanes are finished.
- `LANE_FAIL` out NUM_LANES — set if the lane had no passing tap.
- `CENTER_TAP` out NUM_LANES*TAP_BITS — final tap per lane; lane i occupies bits [i*TAP_BITS +: TAP_BITS].
- `DELAY_LINE_LOAD` out NUM_LANES — per-lane reload-to-default pulse.
- `DELAY_LINE_MOVE` out NUM_LANES — per-lane one-tap step pulse.
- `DELAY_LINE_DIRECTION` out NUM_LANES — 1 = increment; held at 1.
- `EYE_MONITOR_CLEAR_FLAGS` out NUM_LANES — per-lane flag-clear pulse.
- `DELAY_LINE_OUT_OF_RANGE` in NUM_LANES — per-lane delay-line end stop.
- `EYE_MONITOR_EARLY`, `EYE_MONITOR_LATE` in NUM_LANES — per-lane eye-monitor flags.

## Operation
- FSM states: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CLOAD, CSTEP, NEXT, FINISH.
- IDLE → LOAD on `START`. Entering LOAD sets `BUSY`=1, the lane index to 0 and clears `LANE_FAIL`.
- LOAD: pulse `DELAY_LINE_LOAD[lane]`. Set tap=0 and clear the window state (`seen_pass`, `first`, `last`).
- CLEAR: pulse `EYE_MONITOR_CLEAR_FLAGS[lane]`.
- SETTLE: wait `SETTLE_CYCLES` cycles.
- SAMPLE: for `SAMPLE_CYCLES` cycles, OR together `EARLY[lane]|LATE[lane]` into a fail bit.
- EVAL, pass at the current tap:
  - If `!seen_pass`: `first`=tap.
  - Always: `last`=tap and `seen_pass`=1.
- EVAL, fail at the current tap with `seen_pass`=1: the window is closed; go to CLOAD.
- EVAL, end of sweep: if tap == `2**TAP_BITS-1` or `OUT_OF_RANGE[lane]`=1, go to CLOAD.
- EVAL, otherwise: go to STEP.
- STEP: pulse `DELAY_LINE_MOVE[lane]`, tap+=1, go to CLEAR.
- CLOAD: pulse LOAD and set the step counter to 0.
  - Target tap = (`first`+`last`)>>1, computed at TAP_BITS+1 width and floored.
  - If `!seen_pass`: set `LANE_FAIL[lane]` and target = 0.
- CSTEP: one MOVE pulse per cycle until the step count equals the target. If the target is 0, issue no pulses. Then write `CENTER_TAP[lane]`.
- NEXT: if lane == `NUM_LANES-1` go to FINISH, else lane+=1 and go to LOAD.
- FINISH: `DONE` pulses for one cycle, `BUSY`=0, go to IDLE.
- Per-lane control vectors are one-hot on the active lane; all other bits are 0.
- `START` while `BUSY` has no effect. `CENTER_TAP`/`LANE_FAIL` hold until the next accepted `START`.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `LANE_FAIL`=0, `CENTER_TAP`=0, LOAD/MOVE/CLEAR_FLAGS=0, `DELAY_LINE_DIRECTION`=all 1.
- `SYNC_RST` mid-training returns the FSM to IDLE on the next edge with no further pulses. The delay line is left where it was.
- All control pulses are exactly one `FAB_CLK` cycle and registered. At most one pulse is active per cycle.
- The flag-clear-to-sample gap is exactly `SETTLE_CYCLES`.
- Cost per tap: 1 (CLEAR) + SETTLE + SAMPLE + 1 (EVAL) + 1 (STEP). Defaults give 27 cycles.
- Flags are sampled in the cycle they arrive. Input registering is the caller's responsibility.
- `START` is accepted in the cycle after `DONE`.

## Configuration
- `LANE_TRAINER_WINDOW_REPORT_EN`
  - Defined: adds output `WINDOW_WIDTH` (NUM_LANES*(TAP_BITS+1)), per lane = `last`-`first`+1, or 0 on fail. Written together with `CENTER_TAP` and reset to 0.
  - Undefined: the port and its registers are absent; all other behaviour is identical.

## Test plan
Bench configuration: `NUM_LANES`=2, `TAP_BITS`=5, `SETTLE_CYCLES`=2, `SAMPLE_CYCLES`=4, with a tap-tracking delay-line model.
- Lane 0 passes taps 6–14, lane 1 passes taps 3–4 → `CENTER_TAP`={3,10}, `LANE_FAIL`=0, one `DONE`. Lane 0's sweep stops after the tap-15 fail.
- Lane 1 never passes → `LANE_FAIL`=2'b10, lane-1 centre=0, no CSTEP MOVE pulses on lane 1.
- Lane 0 passes taps 28–31 and the limit is reached → centre=29. A run where `OUT_OF_RANGE` asserts at tap 20 with pass 18–25 → centre=19.
- A single `EARLY` glitch in cycle 3 of the sample window at tap 8 (inside pass 5–12) → window 5–7, centre=6.
- `START` pulsed again mid-sweep → ignored. `SYNC_RST` during lane 1 → all outputs at reset values next cycle and no pulses afterwards.
- With the macro defined, the first scenario gives `WINDOW_WIDTH`={2,9}.
